// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: opcodes, format tags and the skid-buffer entry shared by the immediate generator.
package imm_gen_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam int MAX_XLEN = 64;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ZIMM, FMT_SHAMT
    } fmt_e;

    // pc/imm sized for the widest XLEN; narrower builds leave the upper bits zero
    typedef struct packed {
        logic [31:0]         inst;
        logic [MAX_XLEN-1:0] pc;
        logic [MAX_XLEN-1:0] imm;
        fmt_e                fmt;
        logic                illegal;
    } entry_t;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational instruction word -> sign/zero-extended immediate, format tag, illegal flag.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int SHAMT_EXTRACT = 1,
    parameter int ZIMM_EN       = 1
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm, shamt, zimm;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign i_imm  = XLEN'($signed(inst[31:20]));
    assign s_imm  = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign b_imm  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign u_imm  = XLEN'($signed({inst[31:12], 12'b0}));
    assign j_imm  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign shamt  = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
    assign zimm   = XLEN'(inst[19:15]);

    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OP_IMM: begin
                    // funct3 001/101 are the shift-immediate forms
                    fmt = (SHAMT_EXTRACT != 0 && funct3[1:0] == 2'b01) ? FMT_SHAMT : FMT_I;
                    imm = (SHAMT_EXTRACT != 0 && funct3[1:0] == 2'b01) ? shamt : i_imm;
                end
                OP_LOAD, OP_JALR: begin
                    fmt = FMT_I;
                    imm = i_imm;
                end
                OP_SYSTEM: begin
                    fmt = (ZIMM_EN != 0 && funct3[2]) ? FMT_ZIMM : FMT_I;
                    imm = (ZIMM_EN != 0 && funct3[2]) ? zimm : i_imm;
                end
                OP_STORE: begin
                    fmt = FMT_S;
                    imm = s_imm;
                end
                OP_BRANCH: begin
                    fmt = FMT_B;
                    imm = b_imm;
                end
                OP_LUI, OP_AUIPC: begin
                    fmt = FMT_U;
                    imm = u_imm;
                end
                OP_JAL: begin
                    fmt = FMT_J;
                    imm = j_imm;
                end
                OP_OP: ;
                default: illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator behind a 2-entry skid buffer with PC+imm target.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int SHAMT_EXTRACT = 1,
    parameter int ZIMM_EN       = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc
);
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    entry_t          head, skid, incoming;
    logic            head_valid, skid_valid, push, pop, unused_bits;

    imm_decode #(
        .XLEN(XLEN),
        .SHAMT_EXTRACT(SHAMT_EXTRACT),
        .ZIMM_EN(ZIMM_EN)
    ) u_decode (
        .inst(in_inst),
        .imm(dec_imm),
        .fmt(dec_fmt),
        .illegal(dec_illegal)
    );

    assign incoming = '{inst: in_inst, pc: MAX_XLEN'(in_pc), imm: MAX_XLEN'(dec_imm),
                        fmt: fmt_e'(dec_fmt), illegal: dec_illegal};
    assign in_ready = !skid_valid;
    assign push     = in_valid && in_ready;
    assign pop      = head_valid && out_ready;

    // skid only fills when the head is held; it refills the head on the next pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head       <= '0;
            skid       <= '0;
        end else if (flush) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!head_valid || pop) begin
            head_valid <= skid_valid || push;
            skid_valid <= 1'b0;
            if (skid_valid) head <= skid;
            else if (push) head <= incoming;
        end else if (push) begin
            skid       <= incoming;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = head_valid;
    assign out_imm     = head.imm[XLEN-1:0];
    assign out_fmt     = head.fmt;
    assign out_illegal = head.illegal;
    assign out_pc      = head.pc[XLEN-1:0];
    assign out_target  = out_pc + out_imm;
    assign unused_bits = ^{head.inst, head.pc, head.imm};
endmodule
